sb_config_loader: RTL and testbench

//  Upstream feeder for tile switch-box configuration. Deserialises a 1-bit config bitstream into framed
//  {sync, tile address, 32-bit word[, checksum]} records, then drives config_data plus a one-cycle,
//  one-hot config_en strobe to the addressed switch box. Sits between the chip config pin and the tile array.

---
 rtl/sb_config_loader.sv | 151 +++++++++++++++
 tb/tb_sb_config_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sb_config_loader.sv
// Serial bitstream deserialiser driving one-hot switch-box config strobes.
// Optional trailing checksum byte when SB_CFG_LOADER_CHECKSUM_EN is defined.
module sb_config_loader #(
  parameter int         NUM_TILES = 16,
  parameter int         WORD_W    = 32,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_bit,
  input  logic                 cfg_valid,
  output logic [WORD_W-1:0]    config_data,
  output logic [NUM_TILES-1:0] config_en,
  output logic                 busy,
  output logic [7:0]           err_count
);

  typedef enum logic [2:0] {
    HUNT, ADDR, DATA, CHECK, ISSUE, DROP
  } state_t;

  localparam logic [5:0] LAST_W = 6'(WORD_W - 1);
  localparam logic [8:0] NT     = 9'(NUM_TILES);

  state_t                state_q, state_d;
  logic [7:0]            win_q, win_d;
  logic [7:0]            addr_q, addr_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [WORD_W-1:0]     data_q, data_d;
  logic [NUM_TILES-1:0]  en_q, en_d;
  logic [7:0]            err_q, err_d;
  logic [NUM_TILES-1:0]  one;
  logic                  in_range;

`ifdef SB_CFG_LOADER_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
  logic [7:0] sum;

  always_comb begin
    sum = addr_q;
    for (int i = 0; i < WORD_W / 8; i++)
      sum = sum ^ word_q[8*i +: 8];
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
      win_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      en_q    <= '0;
      err_q   <= '0;
`ifdef SB_CFG_LOADER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      en_q    <= en_d;
      err_q   <= err_d;
`ifdef SB_CFG_LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    addr_d  = addr_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
`ifdef SB_CFG_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    unique case (state_q)
      HUNT: if (cfg_valid) begin
        win_d = {win_q[6:0], cfg_bit};
        if ({win_q[6:0], cfg_bit} == SYNC_BYTE) begin
          // Clear the window so busy drops once we return here.
          win_d   = '0;
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: if (cfg_valid) begin
        addr_d = {addr_q[6:0], cfg_bit};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd7) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: if (cfg_valid) begin
        word_d = {word_q[WORD_W-2:0], cfg_bit};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == LAST_W) begin
          cnt_d   = '0;
`ifdef SB_CFG_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = ISSUE;
`endif
        end
      end
`ifdef SB_CFG_LOADER_CHECKSUM_EN
      CHECK: if (cfg_valid) begin
        chk_d = {chk_q[6:0], cfg_bit};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd7) begin
          cnt_d   = '0;
          state_d = ({chk_q[6:0], cfg_bit} == sum) ? ISSUE : DROP;
        end
      end
`endif
      ISSUE:   state_d = HUNT;
      DROP:    state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    one      = '0;
    one[0]   = 1'b1;
    en_d     = '0;
    data_d   = data_q;
    err_d    = err_q;
    in_range = {1'b0, addr_q} < NT;
    if (state_q == ISSUE && in_range) begin
      en_d   = one << addr_q;
      data_d = word_q;
    end
    if (((state_q == ISSUE && !in_range) || state_q == DROP)
        && err_q != 8'hFF)
      err_d = err_q + 8'd1;
  end

  assign config_data = data_q;
  assign config_en   = en_q;
  assign err_count   = err_q;
  assign busy        = (state_q != HUNT) || (win_q[0] == SYNC_BYTE[7]);

endmodule

// File: tb/tb_sb_config_loader.sv
// Scoreboard bench for sb_config_loader (both checksum builds).
module tb_sb_config_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_bit;
  logic        cfg_valid;
  logic [31:0] config_data;
  logic [15:0] config_en;
  logic        busy;
  logic [7:0]  err_count;

  sb_config_loader #(
    .NUM_TILES(16),
    .WORD_W(32),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_bit(cfg_bit),
    .cfg_valid(cfg_valid),
    .config_data(config_data),
    .config_en(config_en),
    .busy(busy),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] en;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;
  int   last_t = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && config_en !== 16'h0) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_strobe: got en=%h data=%h want none",
                 config_en, config_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_en", {16'h0, config_en}, {16'h0, e.en});
        chk("strobe_data", config_data, e.data);
        chk("strobe_latency", cyc, e.cyc);
      end
    end
  end

  function automatic logic [7:0] csum(input logic [7:0] a,
                                      input logic [31:0] w);
    return a ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  task automatic send_bit(input logic b, input bit tog);
    @(negedge clk);
    cfg_bit   = b;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1 last_t = cyc;
    if (tog) begin
      @(negedge clk);
      cfg_bit   = ~b;
      cfg_valid = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input bit tog);
    for (int i = n - 1; i >= 0; i--)
      send_bit(v[i], tog && i != 0);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] w,
                            input logic [7:0] c, input bit tog);
`ifdef SB_CFG_LOADER_CHECKSUM_EN
    send_bits({8'h0, 8'hA5, a, w, c}, 56, tog);
`else
    send_bits({16'h0, 8'hA5, a, w}, 48, tog);
`endif
  endtask

  task automatic expect_strobe(input logic [7:0] a, input logic [31:0] w);
    exp_t e;
    e.en   = 16'd1 << a;
    e.data = w;
    e.cyc  = last_t + 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_bit   = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    cfg_bit   = 1'b0;
    cfg_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_en", {16'h0, config_en}, 32'h0);
    chk("rst_data", config_data, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_err", {24'h0, err_count}, 32'h0);
    reset = 1'b1;
    idle(10);
    chk("idle_en", {16'h0, config_en}, 32'h0);
    chk("idle_busy", {31'h0, busy}, 32'h0);

    send_frame(8'h03, 32'hDEADBEEF, csum(8'h03, 32'hDEADBEEF), 1'b0);
    expect_strobe(8'h03, 32'hDEADBEEF);
    idle(4);
    chk("t2_busy", {31'h0, busy}, 32'h0);
    chk("t2_err", {24'h0, err_count}, 32'h0);

    send_frame(8'h03, 32'hDEADBEEF, csum(8'h03, 32'hDEADBEEF), 1'b1);
    expect_strobe(8'h03, 32'hDEADBEEF);
    idle(4);
    chk("t3_busy", {31'h0, busy}, 32'h0);

    send_frame(8'h10, 32'h11223344, csum(8'h10, 32'h11223344), 1'b0);
    idle(4);
    chk("t4_err", {24'h0, err_count}, 32'h1);
    chk("t4_data", config_data, 32'hDEADBEEF);

`ifdef SB_CFG_LOADER_CHECKSUM_EN
    send_frame(8'h03, 32'hDEADBEEF, 8'h24, 1'b0);
    idle(12);
    chk("t5_err", {24'h0, err_count}, 32'h2);
`else
    send_frame(8'h03, 32'hDEADBEEF, 8'h00, 1'b0);
    expect_strobe(8'h03, 32'hDEADBEEF);
    send_bits(64'h24, 8, 1'b0);
    idle(12);
    chk("t5_err", {24'h0, err_count}, 32'h1);
`endif
    chk("t5_busy", {31'h0, busy}, 32'h0);
    chk("t5_data", config_data, 32'hDEADBEEF);

    send_bits({16'h0, 48'hA5_00_12345678} >> 15, 33, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_data", config_data, 32'h0);
    chk("t6_rst_err", {24'h0, err_count}, 32'h0);
    reset = 1'b1;
    idle(10);
    send_frame(8'h00, 32'h12345678, csum(8'h00, 32'h12345678), 1'b0);
    expect_strobe(8'h00, 32'h12345678);
    idle(4);
    chk("t6_err", {24'h0, err_count}, 32'h0);
    chk("t6_data", config_data, 32'h12345678);

    repeat (300) begin
      send_frame(8'h10, 32'hDEADBEEF, csum(8'h10, 32'hDEADBEEF), 1'b0);
      idle(2);
    end
    idle(4);
    chk("t7_err_sat", {24'h0, err_count}, 32'hFF);
    chk("t7_data", config_data, 32'h12345678);
    chk("sb_drained", q.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
